axis_slice_adder: RTL and testbench
===================================

# axis_slice_adder

Parametrised AXI-Stream adder that joins two operand streams (A, B) of WIDTH bits and returns their sum plus carry-out on a single master stream. Addition is bit-serial by slices: SLICE bits per cycle, LSB first, through a registered carry. This trades latency for a short carry chain, so the block closes timing at wide widths inside the Vedic multiplier partial-product accumulation path. Supports multi-beat operands chained by TLAST.

## Interface
- WIDTH, 32, operand and sum width in bits; must be a multiple of SLICE
- SLICE, 8, bits added per cycle; NSLICE = WIDTH/SLICE (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- s_a_tvalid  in  1  operand A valid
- s_a_tdata  in  WIDTH  operand A
- s_a_tlast  in  1  last beat of multi-beat operand A
- s_a_tready  out  1  operand A accepted
- s_b_tvalid  in  1  operand B valid
- s_b_tdata  in  WIDTH  operand B
- s_b_tlast  in  1  last beat of multi-beat operand B
- s_b_tready  out  1  operand B accepted
- m_sum_tvalid  out  1  result valid
- m_sum_tdata  out  WIDTH  sum bits [WIDTH-1:0]
- m_sum_tlast  out  1  s_a_tlast | s_b_tlast of the captured beat
- m_sum_tuser  out  2  [0] carry-out of this beat; [1] TLAST mismatch (a_tlast != b_tlast)
- m_sum_tready  in  1  downstream accepts result
- busy  out  1  high in ADD or OUT

## Operation
- States: IDLE, ADD, OUT. Reset state IDLE.
- IDLE:
  - s_a_tready = s_b_tready = (state==IDLE) & s_a_tvalid & s_b_tvalid (combinational join).
  - Both streams always transfer on the same edge. Ready never rises for one stream alone.
  - On that edge:
    - latch A, B, both tlasts;
    - slice index ← 0;
    - carry ← carry-in (see Configuration);
    - go to ADD.
- ADD, one slice per cycle:
  - {c, s[i*SLICE +: SLICE]} = a[i] + b[i] + carry; carry ← c; i ← i+1.
  - After slice NSLICE-1, load output registers and go to OUT.
- OUT:
  - m_sum_tvalid=1; tdata, tlast and tuser are held stable until m_sum_tready.
  - On the handshake edge, tvalid drops and the state returns to IDLE.
  - tvalid must not drop without a handshake.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is reported only through tuser[0].
- tuser[1]=1 when the captured tlasts differ. The sum is still produced, and a mismatch is treated as end-of-packet for carry chaining.
- Reset values: s_*_tready 0, m_sum_tvalid 0, m_sum_tdata 0, m_sum_tlast 0, m_sum_tuser 0, busy 0, internal carry 0, chain carry 0.
- Reset mid-ADD or mid-OUT: the operation is discarded, nothing is emitted, and the state returns to IDLE.

## Timing
- Accept edge E0. ADD occupies cycles E0+1 … E0+NSLICE. m_sum_tvalid is high from the cycle after edge E0+NSLICE.
- Latency from input handshake to tvalid: NSLICE+1 cycles (NSLICE=1 gives 2).
- No new operand is accepted while busy. With both inputs valid and m_sum_tready held high, the minimum accept-to-accept period is NSLICE+2 cycles.
- m_sum_tready asserted before tvalid has no effect. Backpressure in OUT stalls indefinitely without corrupting data.
- Ready outputs depend on valid inputs only combinationally. No other input-to-output combinational path exists.

## Configuration
- AXIS_SLICE_ADDER_CHAIN_EN defined:
  - Carry-in of a beat = carry-out of the previous beat, unless the previous beat had m_sum_tlast=1 (or it is the first beat after reset); then carry-in is 0.
  - This forms multi-word additions across beats. The chain carry updates on the OUT handshake.
- Not defined:
  - Carry-in is always 0 and every beat is independent.
  - tlast is only passed through; tuser keeps the same meaning.

## Test plan
- WIDTH=32, SLICE=8: A=0x0000_0003, B=0x0000_0005, tlast=1, m_sum_tready=1 → tdata 0x0000_0008, tuser 0b00, tvalid exactly 5 cycles after the accept edge.
- A=0xFFFF_FFFF, B=0x0000_0001 → tdata 0x0000_0000, tuser[0]=1. Carry ripples through all 4 slices.
- Chain enabled:
  - Beat 1: A=0xFFFF_FFFF, B=1, tlast=0 → 0x0, carry 1.
  - Beat 2: A=0, B=0, tlast=1 → 0x0000_0001.
  - Beat 3: A=0, B=0 → 0x0 (carry cleared after tlast).
  - Chain disabled: beat 2 result is 0x0.
- Join and backpressure:
  - A valid 3 cycles before B → no ready until B is valid, then both readies pulse on the same edge.
  - m_sum_tready low 10 cycles in OUT → tvalid and data stable, busy=1, s_*_tready=0.
- Assert reset during ADD slice 2 → all outputs 0 next edge, no result emitted. A new operand pair after reset yields a correct sum with carry-in 0.
- s_a_tlast=1, s_b_tlast=0 → m_sum_tlast=1, tuser[1]=1. With chain enabled, the next beat has carry-in 0.

Source files
------------

// File: rtl/axis_slice_adder.sv
// axis_slice_adder: joins two AXI-Stream operands and adds them SLICE bits per
// cycle, LSB first, through a registered carry; result leaves on one stream.
// Optional feature macro: AXIS_SLICE_ADDER_CHAIN_EN (carry chained across beats
// until TLAST). Undefined by default: every beat starts with carry-in 0.
module axis_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_a_tvalid,
    input  logic [WIDTH-1:0] s_a_tdata,
    input  logic             s_a_tlast,
    output logic             s_a_tready,
    input  logic             s_b_tvalid,
    input  logic [WIDTH-1:0] s_b_tdata,
    input  logic             s_b_tlast,
    output logic             s_b_tready,
    output logic             m_sum_tvalid,
    output logic [WIDTH-1:0] m_sum_tdata,
    output logic             m_sum_tlast,
    output logic [1:0]       m_sum_tuser,
    input  logic             m_sum_tready,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic [SLICE:0]   slice_sum;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             carry_in;
    logic             last_a;
    logic             last_b;
    logic             accept;
    logic             out_hs;
    logic             last_slice;

    // Join: both operand streams transfer together, only while idle.
    assign accept     = ~reset & (state == IDLE) & s_a_tvalid & s_b_tvalid;
    assign s_a_tready = accept;
    assign s_b_tready = accept;

    assign out_hs     = (state == OUT) & m_sum_tready;
    assign last_slice = (idx == LAST_IDX);
    assign busy       = (state != IDLE);

`ifdef AXIS_SLICE_ADDER_CHAIN_EN
    logic chain_carry;

    // Chain carry follows the emitted beat; a packet end clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_carry <= 1'b0;
        end else if (out_hs) begin
            chain_carry <= m_sum_tuser[0] & ~m_sum_tlast;
        end
    end

    assign carry_in = chain_carry;
`else
    assign carry_in = 1'b0;
`endif

    // One slice add; the new slice enters the sum shifter from the top.
    always_comb begin
        slice_sum = {1'b0, a_sh[SLICE-1:0]}
                  + {1'b0, b_sh[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry};
        sum_next  = (sum_sh >> SLICE)
                  | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
    end

    // Control: IDLE -> ADD for NSLICE cycles -> OUT until downstream takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ADD;
                        idx   <= '0;
                    end
                end
                ADD: begin
                    idx <= idx + 1'b1;
                    if (last_slice) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (m_sum_tready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand shifters, running carry and partial sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            last_a <= 1'b0;
            last_b <= 1'b0;
        end else if (accept) begin
            a_sh   <= s_a_tdata;
            b_sh   <= s_b_tdata;
            sum_sh <= '0;
            carry  <= carry_in;
            last_a <= s_a_tlast;
            last_b <= s_b_tlast;
        end else if (state == ADD) begin
            a_sh   <= a_sh >> SLICE;
            b_sh   <= b_sh >> SLICE;
            sum_sh <= sum_next;
            carry  <= slice_sum[SLICE];
        end
    end

    // Result registers: loaded on the last slice, held until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sum_tvalid <= 1'b0;
            m_sum_tdata  <= '0;
            m_sum_tlast  <= 1'b0;
            m_sum_tuser  <= 2'b00;
        end else if ((state == ADD) && last_slice) begin
            m_sum_tvalid <= 1'b1;
            m_sum_tdata  <= sum_next;
            m_sum_tlast  <= last_a | last_b;
            m_sum_tuser  <= {last_a ^ last_b, slice_sum[SLICE]};
        end else if (out_hs) begin
            m_sum_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_slice_adder.sv
// tb_axis_slice_adder: directed vectors with hand-computed sums for the
// 32-bit / 8-bit-slice adder; expectations follow AXIS_SLICE_ADDER_CHAIN_EN.
module tb_axis_slice_adder;

`ifdef AXIS_SLICE_ADDER_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_a_tvalid = 1'b0;
    logic [31:0] s_a_tdata = '0;
    logic        s_a_tlast = 1'b0;
    logic        s_a_tready;
    logic        s_b_tvalid = 1'b0;
    logic [31:0] s_b_tdata = '0;
    logic        s_b_tlast = 1'b0;
    logic        s_b_tready;
    logic        m_sum_tvalid;
    logic [31:0] m_sum_tdata;
    logic        m_sum_tlast;
    logic [1:0]  m_sum_tuser;
    logic        m_sum_tready = 1'b1;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    axis_slice_adder #(.WIDTH(32), .SLICE(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_a_tvalid   (s_a_tvalid),
        .s_a_tdata    (s_a_tdata),
        .s_a_tlast    (s_a_tlast),
        .s_a_tready   (s_a_tready),
        .s_b_tvalid   (s_b_tvalid),
        .s_b_tdata    (s_b_tdata),
        .s_b_tlast    (s_b_tlast),
        .s_b_tready   (s_b_tready),
        .m_sum_tvalid (m_sum_tvalid),
        .m_sum_tdata  (m_sum_tdata),
        .m_sum_tlast  (m_sum_tlast),
        .m_sum_tuser  (m_sum_tuser),
        .m_sum_tready (m_sum_tready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a pair, wait for the joined ready, return after the accept edge.
    task automatic accept_pair(input logic [31:0] a, input logic [31:0] b,
                               input logic la, input logic lb);
        int n;
        n = 0;
        @(negedge clk);
        s_a_tvalid = 1'b1;
        s_a_tdata  = a;
        s_a_tlast  = la;
        s_b_tvalid = 1'b1;
        s_b_tdata  = b;
        s_b_tlast  = lb;
        #1;
        while (!(s_a_tready && s_b_tready) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_timeout", 64'(s_a_tready & s_b_tready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
    endtask

    // Count negedges from the accept edge until tvalid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!m_sum_tvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_timeout", 64'(m_sum_tvalid), 64'd1);
    endtask

    task automatic beat(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic la, input logic lb,
                        input logic [31:0] es, input logic [1:0] eu,
                        input logic el);
        int lat;
        accept_pair(a, b, la, lb);
        wait_out(lat);
        check({tag, "_data"}, 64'(m_sum_tdata), 64'(es));
        check({tag, "_user"}, 64'(m_sum_tuser), 64'(eu));
        check({tag, "_last"}, 64'(m_sum_tlast), 64'(el));
    endtask

    initial begin
        int lat;
        logic seen;
        logic stable;
        logic [31:0] held;

        // Reset state, with valids high to prove ready stays low in reset.
        s_a_tvalid = 1'b1;
        s_b_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a_ready", 64'(s_a_tready), 64'd0);
        check("rst_b_ready", 64'(s_b_tready), 64'd0);
        check("rst_tvalid", 64'(m_sum_tvalid), 64'd0);
        check("rst_tdata", 64'(m_sum_tdata), 64'd0);
        check("rst_tuser", 64'(m_sum_tuser), 64'd0);
        check("rst_tlast", 64'(m_sum_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        reset = 1'b0;

        // Basic sum and latency.
        accept_pair(32'h3, 32'h5, 1'b1, 1'b1);
        wait_out(lat);
        check("lat", 64'(lat), 64'd5);
        check("b1_data", 64'(m_sum_tdata), 64'h8);
        check("b1_user", 64'(m_sum_tuser), 64'h0);
        check("b1_busy", 64'(busy), 64'd1);

        beat("ripple", 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h0, 2'b01, 1'b1);

        // Multi-beat chain.
        beat("ch1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b0);
        beat("ch2", 32'h0, 32'h0, 1'b1, 1'b1,
             CHAIN ? 32'h1 : 32'h0, 2'b00, 1'b1);
        beat("ch3", 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1);

        beat("mix", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1,
             32'hACF1_3568, 2'b00, 1'b1);

        // Leave carry 1 pending, then a tlast mismatch consumes it.
        beat("msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
             32'h0, 2'b01, 1'b0);
        beat("mm1", 32'h5, 32'h6, 1'b1, 1'b0,
             CHAIN ? 32'hC : 32'hB, 2'b10, 1'b1);
        beat("mm2", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 2'b10, 1'b1);

        // Join: A alone never gets ready.
        @(negedge clk);
        s_a_tvalid = 1'b1;
        s_a_tdata  = 32'h100;
        s_a_tlast  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            seen = seen | s_a_tready | s_b_tready;
            @(negedge clk);
        end
        check("join_early", 64'(seen), 64'd0);
        s_b_tvalid = 1'b1;
        s_b_tdata  = 32'h200;
        s_b_tlast  = 1'b1;
        #1;
        check("join_ready", 64'({s_a_tready, s_b_tready}), 64'd3);
        @(posedge clk);
        @(negedge clk);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        wait_out(lat);
        check("join_data", 64'(m_sum_tdata), 64'h300);

        // Backpressure: 10 stalled cycles with new operands waiting.
        @(negedge clk);
        m_sum_tready = 1'b0;
        accept_pair(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b1);
        wait_out(lat);
        held = m_sum_tdata;
        check("bp_data", 64'(held), 64'hEFBE_D000);
        s_a_tvalid = 1'b1;
        s_b_tvalid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!m_sum_tvalid || m_sum_tdata !== held || !busy ||
                s_a_tready || s_b_tready || m_sum_tuser !== 2'b00)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        m_sum_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_drop", 64'({m_sum_tvalid, busy}), 64'd0);

        // Reset during slice 2 with a chain carry pending.
        beat("pre_rst", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b0);
        accept_pair(32'h11, 32'h22, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", 64'({m_sum_tvalid, m_sum_tlast, m_sum_tuser,
                                  busy, s_a_tready, s_b_tready}), 64'd0);
        check("mid_rst_data", 64'(m_sum_tdata), 64'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | m_sum_tvalid | busy;
        end
        check("rst_no_emit", 64'(seen), 64'd0);
        beat("post_rst", 32'h7, 32'h9, 1'b1, 1'b1, 32'h10, 2'b00, 1'b1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
